// File: rtl/demo_recorder.sv
// demo_recorder: encodes live channel/waveform play as duration-stamped words written to a demo RAM
module demo_recorder #(
  parameter int NUM_CHANNELS = 25,
  parameter int DEPTH = 128,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int TICK_CYCLES = 1000000,
  parameter int DUR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_CHANNELS-1:0] channel_ena,
  input  logic [1:0]              waveform,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [95:0]             wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    full,
  output logic [ADDR_W:0]         length
);
  localparam int S = NUM_CHANNELS + 2;
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DUR_W-1:0] SAT = DUR_W'((1 << DUR_W) - 2);
  typedef enum logic [1:0] {IDLE, RECORD, TERM, DONE} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [DUR_W-1:0] dur, d_eff;
  logic [S-1:0] snap, live;
  logic [ADDR_W-1:0] addr;
  logic tick, changed, emit, last;
  logic [95:0] word;
  // saturation emits dur+1, which equals the all-ones duration, so d_eff serves every emit
  always_comb begin
    live = {waveform, channel_ena};
    tick = state == RECORD && presc == PW'(TICK_CYCLES - 1);
    d_eff = dur + DUR_W'(tick);
    changed = live != snap;
    emit = (stop || changed) ? d_eff != '0 : tick && dur == SAT;
    last = emit && addr == ADDR_W'(DEPTH - 2);
    word = '0;
    word[80 +: DUR_W] = d_eff;
    word[78 - NUM_CHANNELS +: S] = snap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      full <= 1'b0;
      length <= '0;
      addr <= '0;
      presc <= '0;
      dur <= '0;
      snap <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= RECORD;
          busy <= 1'b1;
          done <= 1'b0;
          full <= 1'b0;
          addr <= '0;
          length <= '0;
          presc <= '0;
          dur <= '0;
          snap <= live;
        end
        RECORD: begin
          presc <= tick ? '0 : presc + 1'b1;
          dur <= emit ? '0 : d_eff;
          snap <= changed ? live : snap;
          if (emit) begin
            wr_en <= 1'b1;
            wr_addr <= addr;
            wr_data <= word;
            addr <= addr + 1'b1;
            length <= length + 1'b1;
          end
          if (stop || last) state <= TERM;
          if (last) full <= 1'b1;
        end
        TERM: begin
          wr_en <= 1'b1;
          wr_addr <= addr;
          wr_data <= '0;
          length <= length + 1'b1;
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demo_recorder.sv
// tb_demo_recorder: directed scenario tests for demo_recorder with small tick/depth parameters
module tb_demo_recorder;
  localparam int NC = 25, DEPTH = 8, AW = 3, TICK = 4, DW = 4;
  logic clk = 1'b0, rst, start, stop;
  logic [NC-1:0] channel_ena;
  logic [1:0] waveform;
  logic wr_en, busy, done, full;
  logic [AW-1:0] wr_addr;
  logic [95:0] wr_data;
  logic [AW:0] length;
  int checks = 0, errors = 0;

  demo_recorder #(.NUM_CHANNELS(NC), .DEPTH(DEPTH), .TICK_CYCLES(TICK), .DUR_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .channel_ena(channel_ena),
    .waveform(waveform), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .full(full), .length(length)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; channel_ena = '0; waveform = 2'd0;
    cyc; cyc;
    rst = 1'b0;
  endtask

  task automatic begin_rec(input logic [NC-1:0] e, input logic [1:0] w);
    channel_ena = e; waveform = w; start = 1'b1;
    cyc;
    start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== '0) begin
      errors++; $display("FAIL reset_write: got %h expected 0", {wr_en, wr_addr, wr_data});
    end
    checks++;
    if ({busy, done, full, length} !== '0) begin
      errors++; $display("FAIL reset_status: got %h expected 0", {busy, done, full, length});
    end
  endtask

  task automatic test_basic;
    do_reset;
    begin_rec(NC'(1), 2'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    repeat (12) cyc;
    channel_ena = NC'(2);
    cyc;
    checks++;
    if ({wr_en, wr_addr} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL basic_addr: got %h expected %h", {wr_en, wr_addr}, {1'b1, 3'd0});
    end
    checks++;
    if (wr_data !== {16'd3, 2'd0, 25'd1, 53'd0}) begin
      errors++; $display("FAIL basic_data: got %h expected %h", wr_data, {16'd3, 2'd0, 25'd1, 53'd0});
    end
  endtask

  task automatic test_glitch;
    do_reset;
    begin_rec(NC'(1), 2'd0);
    channel_ena = NC'(9);
    for (int i = 0; i < 8; i++) begin
      cyc;
      checks++;
      if (wr_en !== 1'b0) begin errors++; $display("FAIL glitch_nowrite[%0d]: got %b expected 0", i, wr_en); end
    end
    stop = 1'b1;
    cyc;
    stop = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd0, 16'd2, 2'd0, 25'd9, 53'd0}) begin
      errors++; $display("FAIL glitch_snapshot: got %h expected %h", {wr_en, wr_addr, wr_data},
                         {1'b1, 3'd0, 16'd2, 2'd0, 25'd9, 53'd0});
    end
  endtask

  task automatic test_saturation;
    do_reset;
    begin_rec(NC'(5), 2'd0);
    for (int i = 1; i < 60; i++) begin
      cyc;
      checks++;
      if (wr_en !== 1'b0) begin errors++; $display("FAIL sat_early_write[%0d]: got %b expected 0", i, wr_en); end
    end
    cyc;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd0, 16'd15, 2'd0, 25'd5, 53'd0}) begin
      errors++; $display("FAIL sat_word: got %h expected %h", {wr_en, wr_addr, wr_data},
                         {1'b1, 3'd0, 16'd15, 2'd0, 25'd5, 53'd0});
    end
    repeat (8) cyc;
    stop = 1'b1;
    cyc;
    stop = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd1, 16'd2, 2'd0, 25'd5, 53'd0}) begin
      errors++; $display("FAIL sat_restart: got %h expected %h", {wr_en, wr_addr, wr_data},
                         {1'b1, 3'd1, 16'd2, 2'd0, 25'd5, 53'd0});
    end
    checks++;
    if (length !== 4'd2) begin errors++; $display("FAIL sat_length: got %0d expected 2", length); end
  endtask

  task automatic test_stop_flush;
    do_reset;
    begin_rec(NC'(3), 2'd2);
    repeat (8) cyc;
    stop = 1'b1; start = 1'b1;
    cyc;
    stop = 1'b0; start = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd0, 16'd2, 2'd2, 25'd3, 53'd0}) begin
      errors++; $display("FAIL stop_word: got %h expected %h", {wr_en, wr_addr, wr_data},
                         {1'b1, 3'd0, 16'd2, 2'd2, 25'd3, 53'd0});
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy_term: got %b expected 1", busy); end
    cyc;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd1, 96'd0}) begin
      errors++; $display("FAIL stop_terminator: got %h expected %h", {wr_en, wr_addr, wr_data}, {1'b1, 3'd1, 96'd0});
    end
    cyc;
    checks++;
    if ({wr_en, done, length, busy, full} !== {1'b0, 1'b1, 4'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL stop_done: got %b expected %b", {wr_en, done, length, busy, full},
                         {1'b0, 1'b1, 4'd2, 1'b0, 1'b0});
    end
    start = 1'b1;
    cyc;
    start = 1'b0;
    checks++;
    if ({done, busy, length, full} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL restart_from_done: got %b expected %b", {done, busy, length, full},
                         {1'b0, 1'b1, 4'd0, 1'b0});
    end
  endtask

  task automatic test_full;
    do_reset;
    begin_rec(NC'(1), 2'd0);
    repeat (4) cyc;
    for (int k = 0; k < 7; k++) begin
      channel_ena = NC'(k + 2);
      cyc;
      checks++;
      if ({wr_en, wr_addr} !== {1'b1, AW'(k)}) begin
        errors++; $display("FAIL full_addr[%0d]: got %h expected %h", k, {wr_en, wr_addr}, {1'b1, AW'(k)});
      end
      checks++;
      if (wr_data !== {16'd1, 2'd0, NC'(k + 1), 53'd0}) begin
        errors++; $display("FAIL full_data[%0d]: got %h expected %h", k, wr_data, {16'd1, 2'd0, NC'(k + 1), 53'd0});
      end
      if (k < 6) repeat (3) cyc;
    end
    cyc;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd7, 96'd0}) begin
      errors++; $display("FAIL full_terminator: got %h expected %h", {wr_en, wr_addr, wr_data}, {1'b1, 3'd7, 96'd0});
    end
    cyc;
    checks++;
    if ({done, full, busy, length} !== {1'b1, 1'b1, 1'b0, 4'd8}) begin
      errors++; $display("FAIL full_status: got %b expected %b", {done, full, busy, length}, {1'b1, 1'b1, 1'b0, 4'd8});
    end
    for (int i = 0; i < 4; i++) begin
      channel_ena = ~channel_ena;
      cyc;
      checks++;
      if ({wr_en, length} !== {1'b0, 4'd8}) begin
        errors++; $display("FAIL full_hold[%0d]: got %b expected %b", i, {wr_en, length}, {1'b0, 4'd8});
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    begin_rec(NC'(1), 2'd0);
    repeat (4) cyc;
    channel_ena = NC'(2);
    cyc;
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL mid_segment: got %b expected 1", wr_en); end
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, full, length} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {wr_en, wr_addr, wr_data, busy, done, full, length});
    end
    for (int i = 0; i < 3; i++) begin
      cyc;
      checks++;
      if ({wr_en, busy} !== 2'b00) begin
        errors++; $display("FAIL mid_no_terminator[%0d]: got %b expected 00", i, {wr_en, busy});
      end
    end
    begin_rec(NC'(6), 2'd1);
    repeat (4) cyc;
    stop = 1'b1;
    cyc;
    stop = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd0, 16'd1, 2'd1, 25'd6, 53'd0}) begin
      errors++; $display("FAIL mid_rerecord: got %h expected %h", {wr_en, wr_addr, wr_data},
                         {1'b1, 3'd0, 16'd1, 2'd1, 25'd6, 53'd0});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_saturation;
    test_stop_flush;
    test_full;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/demo_recorder.md
Name: demo_recorder

Overview:
- Captures live play (channel enables plus waveform select) and encodes it as a sequence of 96-bit duration-stamped segment words.
- Writes the words into a demo RAM through a single write port. The demo playback path replays these words.
- Sits beside the channel-select logic in the top level and samples the same debounced, clk-synchronous signals that feed the channel mixer.

Parameters:
- NUM_CHANNELS, 25, number of channel enable bits (must be <= 78)
- DEPTH, 128, RAM depth in words (must be >= 2)
- ADDR_W, $clog2(DEPTH), write address width
- TICK_CYCLES, 1000000, clk cycles per duration tick (10 ms at 100 MHz)
- DUR_W, 16, duration field width (must be <= 16)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin recording (level sampled each cycle)
- stop  in  1  end recording
- channel_ena  in  NUM_CHANNELS  live channel enables
- waveform  in  2  live waveform select
- wr_en  out  1  RAM write strobe, one cycle per word
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  96  RAM write data
- busy  out  1  high while recording or terminating
- done  out  1  high in DONE until next start
- full  out  1  recording ended because RAM filled
- length  out  ADDR_W+1  words written, terminator included

Behaviour:
- Word format:
  - [95:80] duration in ticks, zero-extended from DUR_W.
  - [79:78] waveform.
  - [77:78-NUM_CHANNELS] channel_ena.
  - Remaining bits 0.
  - Terminator word is all zeros (duration 0 marks end of song).
- States: IDLE, RECORD, TERM, DONE.
- Reset: state IDLE; wr_en, wr_addr, wr_data, busy, done, full, length all 0. Reset mid-record abandons the take; no terminator is written.
- Registered outputs: all outputs are registered. An input sampled at edge N produces its write during cycle N+1 (wr_en, wr_addr and wr_data valid together). At most one write per cycle.
- start:
  - Honoured in IDLE and DONE, ignored in RECORD and TERM.
  - Clears the address to 0, length to 0, done to 0, full to 0, the tick prescaler to 0 and dur to 0.
  - Loads snapshot = {waveform, channel_ena}. Next state is RECORD.
- Tick prescaler: counts 0..TICK_CYCLES-1 in RECORD. tick=1 on the wrap cycle.
- Effective duration: d' = dur + tick.
- RECORD, evaluated each cycle in priority order:
  1. stop: if d' > 0, emit {d', snapshot}. Go to TERM. A stop arriving with start in the same cycle is still a stop.
  2. Input change ({waveform, channel_ena} != snapshot):
     - If d' == 0, replace the snapshot silently (sub-tick segments are dropped).
     - Otherwise emit {d', snapshot}, set dur <= 0 and load the snapshot from the inputs.
  3. Saturation: if tick and dur == 2^DUR_W-2, emit {2^DUR_W-1, snapshot} and set dur <= 0. The snapshot is unchanged and the segment continues in the next word.
  4. Otherwise dur <= d'.
- Emit rule: writes wr_data at the current address, then increments the address and length.
- Capacity: segment words occupy addresses 0..DEPTH-2, and address DEPTH-1 is reserved for the terminator. If an emit lands at DEPTH-2, set full <= 1 and go to TERM regardless of stop.
- TERM: writes the terminator at the current address for one cycle, increments length, then goes to DONE.
- busy: 1 in RECORD and TERM.
- DONE: done = 1. Outputs hold, wr_en = 0.

Test Plan (TICK_CYCLES=4, DEPTH=8, DUR_W=4, NUM_CHANNELS=25):
- Basic segment: start with ena=1 and wf=0, hold 12 cycles, then set ena=2. Required: next cycle wr_en=1, wr_addr=0, wr_data[95:80]=3, [77:53]=1.
- Glitch drop: start, change ena within the first 3 cycles (before the first tick). Required: no wr_en, and the snapshot becomes the new value.
- Saturation: start, hold ena=5 for 60 cycles. Required: one write at tick 15 with duration 15 and ena=5 at addr 0, then dur restarts from 0.
- Stop flush: record 2 ticks of ena=3, then pulse stop. Required: write {2, ena=3} at addr 0, next cycle an all-zero word at addr 1, then done=1, length=2, busy=0, full=0.
- Full: generate 7 segments. Required: addrs 0..6 are segments, addr 7 is the terminator, full=1, done=1, length=8, and further input changes produce no writes.
- Reset mid-record: assert rst after 1 segment. Required: every output is 0 next cycle, no terminator is written, and start afterwards records from addr 0.
